alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- ID/EX-side driver of the ALU interface. Decodes the main-control ALU op and the R-type funct field into the 4-bit ALU control code, then registers the operands and shamt that drive the combinational ALU.
- Captures the ALU result and zero flag into an EX output register and resolves beq branches.
- Two-stage valid/ready pipeline (S1 = issue register feeding ALU, S2 = result register) between decode and memory stage.

Parameters:
- W, 32, datapath width (fixed at 32 for ALU compatibility)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  decode offers instruction
- id_ready  out  1  stage accepts this cycle
- id_alu_op  in  2  00 add (lw/sw/addi), 01 sub (beq), 10 R-type (use funct), 11 and (andi)
- id_funct  in  6  R-type funct field
- id_shamt  in  5  shift amount
- id_rs_val, id_rt_val  in  32  register operands
- id_imm  in  32  sign-extended immediate
- id_alu_src  in  1  1 selects id_imm as second operand
- id_branch  in  1  instruction is beq
- id_pc4  in  32  PC+4 of instruction
- id_rs_idx, id_rt_idx, id_rd_idx  in  5 each  register indices; id_rd_idx is the destination
- id_reg_write  in  1  instruction writes id_rd_idx
- alu_rs, alu_rt  out  32  ALU operands, straight from S1
- alu_shamt  out  5  from S1
- alu_ctrl  out  4  from S1
- alu_result  in  32  combinational ALU result
- alu_zero  in  1  ALU zero flag
- ex_valid  out  1  S2 holds a result
- ex_ready  in  1  downstream accepts
- ex_result  out  32  captured result
- ex_rd_idx  out  5  destination register
- ex_reg_write  out  1  write enable
- ex_illegal  out  1  unsupported funct
- ex_br_taken  out  1  beq taken
- ex_br_target  out  32  id_pc4 + (id_imm << 2), modulo 2^32
- flush  out  1  one-cycle squash pulse to fetch/decode

Behaviour:
- Reset (async): all S1 and S2 registers, ex_*, alu_*, and flush cleared to 0; alu_ctrl = 0000.
- Decode (combinational, captured into S1):
  - alu_op 00 -> 0010; 01 -> 0110; 11 -> 0000.
  - alu_op 10 uses funct: 0x20 -> 0010, 0x22 -> 0110, 0x24 -> 0000, 0x27 -> 1100, 0x2A -> 0111, 0x00 -> 1110.
  - Any other funct -> 1111, with illegal bit set and reg_write forced to 0.
- Second operand = id_alu_src ? id_imm : id_rt_val.
- Handshake:
  - s2_free = !ex_valid || ex_ready.
  - s1_adv = s1_valid && s2_free.
  - id_ready = !s1_valid || s2_free.
  - S1 loads on id_valid && id_ready.
  - S1 clears when it advances without a new load.
- S2 loads alu_result, ex_br_taken = s1_branch && alu_zero, and target on s1_adv.
- ex_valid clears when ex_ready && ex_valid and nothing advances.
- Latency: instruction accepted at edge N appears on ex_* after edge N+1 when unstalled. Throughput is 1 per cycle.
- Stall: while ex_valid && !ex_ready, S2 and S1 hold, and alu_* stays stable.
- Branch: on the edge where S2 captures a taken branch:
  - flush is asserted for exactly the following cycle.
  - S1 is invalidated at that same edge, including any instruction loaded that edge.
  - During the flush cycle, id_ready = 0.
- Not-taken branch or non-branch: flush stays 0. Branch instructions have ex_reg_write = 0.
- Reset mid-stall: everything clears immediately; no partial result is held.

Optional Feature:
- Macro ALU_FWD_EN.
- Defined: S1 operand bypass. At S1 load, if S2 would hold (or is loading this edge from S1) an instruction with reg_write = 1 and a nonzero destination equal to id_rs_idx (or to id_rt_idx when alu_src = 0), the newest matching result replaces the register value.
  - Priority: S1's ALU output over S2's captured ex_result.
- Undefined: operands are taken verbatim from id_*. Hazard avoidance is decode's responsibility.

Test Plan:
- R-type add: rs = 5, rt = 7, funct 0x20 -> alu_ctrl = 0010 one cycle later; ex_result = 12, ex_valid one cycle after that.
- sll: rt = 0x1, shamt = 4, funct 0x00 -> alu_ctrl = 1110, ex_result = 0x10; funct 0x3F -> alu_ctrl = 1111, ex_illegal = 1, ex_reg_write = 0.
- beq taken: rs = rt = 9, pc4 = 0x100, imm = 3 -> ex_br_taken = 1, ex_br_target = 0x10C, flush high exactly one cycle, following S1 instruction dropped. With rs = 9, rt = 8 -> taken = 0, no flush.
- Back-pressure: hold ex_ready = 0 for 3 cycles with 3 instructions offered -> id_ready drops after S1 fills, no loss or duplication, in-order release on ex_ready = 1.
- Async reset asserted mid-stall, between clock edges -> all outputs 0 immediately.
- ALU_FWD_EN: add $3 = 2 + 2, then add $4 = $3 + 1 with stale id_rs_val = 0 -> ex_result = 5. Without the macro -> 1.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX-side driver of the combinational ALU.
// S1 (issue register) holds the decoded ALU control, operands and shamt that
// drive the external ALU. S2 (result register) captures the ALU result,
// resolves beq, and presents the instruction to the memory stage.
// A taken branch raises flush for one cycle and squashes S1.
// Optional build macro: ALU_FWD_EN. When defined, operands are bypassed from
// S1/S2 at S1 load. When undefined, operands come from id_* without change.
module alu_issue_stage #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         id_valid,
  output logic         id_ready,
  input  logic [1:0]   id_alu_op,
  input  logic [5:0]   id_funct,
  input  logic [4:0]   id_shamt,
  input  logic [W-1:0] id_rs_val,
  input  logic [W-1:0] id_rt_val,
  input  logic [W-1:0] id_imm,
  input  logic         id_alu_src,
  input  logic         id_branch,
  input  logic [W-1:0] id_pc4,
  input  logic [4:0]   id_rs_idx,
  input  logic [4:0]   id_rt_idx,
  input  logic [4:0]   id_rd_idx,
  input  logic         id_reg_write,
  output logic [W-1:0] alu_rs,
  output logic [W-1:0] alu_rt,
  output logic [4:0]   alu_shamt,
  output logic [3:0]   alu_ctrl,
  input  logic [W-1:0] alu_result,
  input  logic         alu_zero,
  output logic         ex_valid,
  input  logic         ex_ready,
  output logic [W-1:0] ex_result,
  output logic [4:0]   ex_rd_idx,
  output logic         ex_reg_write,
  output logic         ex_illegal,
  output logic         ex_br_taken,
  output logic [W-1:0] ex_br_target,
  output logic         flush
);

  typedef enum logic [3:0] {
    CTRL_AND = 4'b0000,
    CTRL_ADD = 4'b0010,
    CTRL_SUB = 4'b0110,
    CTRL_SLT = 4'b0111,
    CTRL_NOR = 4'b1100,
    CTRL_SLL = 4'b1110,
    CTRL_ILL = 4'b1111
  } alu_ctrl_e;

  alu_ctrl_e    dec_ctrl;
  logic         dec_illegal;
  logic         dec_reg_write;
  logic [W-1:0] op_a;
  logic [W-1:0] op_rt;
  logic [W-1:0] op_b;

  logic         s1_valid;
  logic         s1_branch;
  logic         s1_reg_write;
  logic         s1_illegal;
  logic [4:0]   s1_rd_idx;
  logic [W-1:0] s1_br_target;

  logic         s2_free;
  logic         s1_adv;
  logic         s1_load;
  logic         br_squash;

  // Main-control op and funct to ALU control code; unknown funct is illegal
  always_comb begin
    dec_ctrl    = CTRL_ADD;
    dec_illegal = 1'b0;
    case (id_alu_op)
      2'b00: dec_ctrl = CTRL_ADD;
      2'b01: dec_ctrl = CTRL_SUB;
      2'b11: dec_ctrl = CTRL_AND;
      default: begin
        case (id_funct)
          6'h20:   dec_ctrl = CTRL_ADD;
          6'h22:   dec_ctrl = CTRL_SUB;
          6'h24:   dec_ctrl = CTRL_AND;
          6'h27:   dec_ctrl = CTRL_NOR;
          6'h2A:   dec_ctrl = CTRL_SLT;
          6'h00:   dec_ctrl = CTRL_SLL;
          default: begin
            dec_ctrl    = CTRL_ILL;
            dec_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign dec_reg_write = id_reg_write && !dec_illegal && !id_branch;

`ifdef ALU_FWD_EN
  // Operand bypass; S1 is the newer producer so its ALU output wins over S2.
  // S1 can only be loaded while occupied if it is advancing this edge.
  always_comb begin
    op_a  = id_rs_val;
    op_rt = id_rt_val;
    if (ex_valid && ex_reg_write && (ex_rd_idx != 5'd0)) begin
      if (ex_rd_idx == id_rs_idx) op_a  = ex_result;
      if (ex_rd_idx == id_rt_idx) op_rt = ex_result;
    end
    if (s1_valid && s1_reg_write && (s1_rd_idx != 5'd0)) begin
      if (s1_rd_idx == id_rs_idx) op_a  = alu_result;
      if (s1_rd_idx == id_rt_idx) op_rt = alu_result;
    end
  end
`else
  logic unused_idx;
  assign unused_idx = ^{id_rs_idx, id_rt_idx};
  assign op_a       = id_rs_val;
  assign op_rt      = id_rt_val;
`endif

  assign op_b = id_alu_src ? id_imm : op_rt;

  assign s2_free   = !ex_valid || ex_ready;
  assign s1_adv    = s1_valid && s2_free;
  assign id_ready  = (!s1_valid || s2_free) && !flush;
  assign s1_load   = id_valid && id_ready;
  assign br_squash = s1_adv && s1_branch && alu_zero;

  // S1 issue register: decoded instruction driving the ALU
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_branch    <= 1'b0;
      s1_reg_write <= 1'b0;
      s1_illegal   <= 1'b0;
      s1_rd_idx    <= '0;
      s1_br_target <= '0;
      alu_rs       <= '0;
      alu_rt       <= '0;
      alu_shamt    <= '0;
      alu_ctrl     <= '0;
    end else begin
      if (br_squash)    s1_valid <= 1'b0;
      else if (s1_load) s1_valid <= 1'b1;
      else if (s1_adv)  s1_valid <= 1'b0;
      if (s1_load) begin
        s1_branch    <= id_branch;
        s1_reg_write <= dec_reg_write;
        s1_illegal   <= dec_illegal;
        s1_rd_idx    <= id_rd_idx;
        s1_br_target <= id_pc4 + (id_imm << 2);
        alu_rs       <= op_a;
        alu_rt       <= op_b;
        alu_shamt    <= id_shamt;
        alu_ctrl     <= dec_ctrl;
      end
    end
  end

  // S2 result register, branch resolution and one-cycle flush pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_result    <= '0;
      ex_rd_idx    <= '0;
      ex_reg_write <= 1'b0;
      ex_illegal   <= 1'b0;
      ex_br_taken  <= 1'b0;
      ex_br_target <= '0;
      flush        <= 1'b0;
    end else begin
      flush <= br_squash;
      if (s1_adv) begin
        ex_valid     <= 1'b1;
        ex_result    <= alu_result;
        ex_rd_idx    <= s1_rd_idx;
        ex_reg_write <= s1_reg_write;
        ex_illegal   <= s1_illegal;
        ex_br_taken  <= s1_branch && alu_zero;
        ex_br_target <= s1_br_target;
      end else if (ex_ready) begin
        ex_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed vectors plus hand-written multi-cycle sequences
// for alu_issue_stage, with a behavioural ALU closing the loop.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic [4:0]  id_shamt;
  logic [31:0] id_rs_val, id_rt_val, id_imm, id_pc4;
  logic        id_alu_src, id_branch, id_reg_write;
  logic [4:0]  id_rs_idx, id_rt_idx, id_rd_idx;
  logic [31:0] alu_rs, alu_rt, alu_result;
  logic [4:0]  alu_shamt;
  logic [3:0]  alu_ctrl;
  logic        alu_zero;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_result, ex_br_target;
  logic [4:0]  ex_rd_idx;
  logic        ex_reg_write, ex_illegal, ex_br_taken, flush;

  int unsigned total = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.W(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_alu_op(id_alu_op), .id_funct(id_funct), .id_shamt(id_shamt),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_branch(id_branch), .id_pc4(id_pc4),
    .id_rs_idx(id_rs_idx), .id_rt_idx(id_rt_idx), .id_rd_idx(id_rd_idx),
    .id_reg_write(id_reg_write), .alu_rs(alu_rs), .alu_rt(alu_rt),
    .alu_shamt(alu_shamt), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .alu_zero(alu_zero), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_result(ex_result), .ex_rd_idx(ex_rd_idx), .ex_reg_write(ex_reg_write),
    .ex_illegal(ex_illegal), .ex_br_taken(ex_br_taken),
    .ex_br_target(ex_br_target), .flush(flush)
  );

  // Behavioural combinational ALU driven by the S1 outputs
  always_comb begin
    case (alu_ctrl)
      4'b0010: alu_result = alu_rs + alu_rt;
      4'b0110: alu_result = alu_rs - alu_rt;
      4'b0000: alu_result = alu_rs & alu_rt;
      4'b0001: alu_result = alu_rs | alu_rt;
      4'b1100: alu_result = ~(alu_rs | alu_rt);
      4'b0111: alu_result = {31'd0, $signed(alu_rs) < $signed(alu_rt)};
      4'b1110: alu_result = alu_rt << alu_shamt;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic        src;
    logic [3:0]  exp_ctrl;
    logic [31:0] exp_res;
    logic        exp_ill;
    logic        exp_rw;
  } vec_t;

  vec_t vecs [11];
  logic [31:0] got [$];
  logic        rdy;
  int unsigned idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] funct, input logic [4:0] shamt,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                       input logic src, input logic br, input logic [31:0] pc4,
                       input logic [4:0] rsi, input logic [4:0] rti, input logic [4:0] rdi,
                       input logic rw);
    id_valid = 1'b1; id_alu_op = op; id_funct = funct; id_shamt = shamt;
    id_rs_val = rs; id_rt_val = rt; id_imm = imm; id_alu_src = src;
    id_branch = br; id_pc4 = pc4; id_rs_idx = rsi; id_rt_idx = rti;
    id_rd_idx = rdi; id_reg_write = rw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    id_valid = 0; id_alu_op = 0; id_funct = 0; id_shamt = 0; id_rs_val = 0;
    id_rt_val = 0; id_imm = 0; id_alu_src = 0; id_branch = 0; id_pc4 = 0;
    id_rs_idx = 0; id_rt_idx = 0; id_rd_idx = 0; id_reg_write = 0;
    ex_ready = 1'b1;

    //          op     funct  sh  rs            rt            imm           src  ctrl     result        ill  rw
    vecs[0]  = '{2'b10, 6'h20, 0, 32'd5,        32'd7,        32'd0,        0, 4'b0010, 32'd12,       0, 1};
    vecs[1]  = '{2'b10, 6'h22, 0, 32'd10,       32'd3,        32'd0,        0, 4'b0110, 32'd7,        0, 1};
    vecs[2]  = '{2'b10, 6'h24, 0, 32'hF0F0,     32'hFF00,     32'd0,        0, 4'b0000, 32'hF000,     0, 1};
    vecs[3]  = '{2'b10, 6'h27, 0, 32'd0,        32'd0,        32'd0,        0, 4'b1100, 32'hFFFFFFFF, 0, 1};
    vecs[4]  = '{2'b10, 6'h2A, 0, 32'hFFFFFFFF, 32'd1,        32'd0,        0, 4'b0111, 32'd1,        0, 1};
    vecs[5]  = '{2'b10, 6'h00, 4, 32'd0,        32'd1,        32'd0,        0, 4'b1110, 32'h10,       0, 1};
    vecs[6]  = '{2'b10, 6'h3F, 0, 32'd4,        32'd4,        32'd0,        0, 4'b1111, 32'd0,        1, 0};
    vecs[7]  = '{2'b00, 6'h00, 0, 32'd100,      32'd0,        32'hFFFFFFFF, 1, 4'b0010, 32'd99,       0, 1};
    vecs[8]  = '{2'b01, 6'h00, 0, 32'd9,        32'd9,        32'd0,        0, 4'b0110, 32'd0,        0, 1};
    vecs[9]  = '{2'b11, 6'h00, 0, 32'hFF,       32'd0,        32'h0F,       1, 4'b0000, 32'h0F,       0, 1};
    vecs[10] = '{2'b00, 6'h3F, 0, 32'd1,        32'd2,        32'd0,        0, 4'b0010, 32'd3,        0, 1};

    // Reset state
    do_reset();
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_ex_result", ex_result, 32'd0);
    chk("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    chk("rst_alu_rs", alu_rs, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_id_ready", {31'd0, id_ready}, 32'd1);

    // Single-instruction vectors: ctrl one edge after accept, result one more
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].op, vecs[i].funct, vecs[i].shamt, vecs[i].rs, vecs[i].rt,
            vecs[i].imm, vecs[i].src, 1'b0, 32'd0, 5'd1, 5'd2, 5'd3, 1'b1);
      tick();
      chk($sformatf("v%0d_alu_ctrl", i), {28'd0, alu_ctrl}, {28'd0, vecs[i].exp_ctrl});
      chk($sformatf("v%0d_ex_valid_early", i), {31'd0, ex_valid}, 32'd0);
      id_valid = 1'b0;
      tick();
      chk($sformatf("v%0d_ex_valid", i), {31'd0, ex_valid}, 32'd1);
      chk($sformatf("v%0d_ex_result", i), ex_result, vecs[i].exp_res);
      chk($sformatf("v%0d_ex_illegal", i), {31'd0, ex_illegal}, {31'd0, vecs[i].exp_ill});
      chk($sformatf("v%0d_ex_reg_write", i), {31'd0, ex_reg_write}, {31'd0, vecs[i].exp_rw});
      chk($sformatf("v%0d_flush", i), {31'd0, flush}, 32'd0);
    end
    tick();

    // beq taken: follower offered behind it must be dropped
    drive(2'b01, 6'h00, 0, 32'd9, 32'd9, 32'd3, 0, 1'b1, 32'h100, 5'd1, 5'd2, 5'd0, 1'b1);
    tick();
    drive(2'b10, 6'h20, 0, 32'd1, 32'd1, 32'd0, 0, 1'b0, 32'h104, 5'd1, 5'd2, 5'd5, 1'b1);
    tick();
    chk("bt_ex_br_taken", {31'd0, ex_br_taken}, 32'd1);
    chk("bt_ex_br_target", ex_br_target, 32'h10C);
    chk("bt_ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
    chk("bt_flush_high", {31'd0, flush}, 32'd1);
    chk("bt_id_ready_low", {31'd0, id_ready}, 32'd0);
    tick();
    id_valid = 1'b0;
    chk("bt_flush_low", {31'd0, flush}, 32'd0);
    chk("bt_ex_valid_clear", {31'd0, ex_valid}, 32'd0);
    tick();
    chk("bt_follower_dropped", {31'd0, ex_valid}, 32'd0);

    // beq not taken: no flush, follower proceeds
    drive(2'b01, 6'h00, 0, 32'd9, 32'd8, 32'd3, 0, 1'b1, 32'h100, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    drive(2'b10, 6'h20, 0, 32'd1, 32'd1, 32'd0, 0, 1'b0, 32'h104, 5'd1, 5'd2, 5'd5, 1'b1);
    tick();
    id_valid = 1'b0;
    chk("bn_ex_br_taken", {31'd0, ex_br_taken}, 32'd0);
    chk("bn_flush", {31'd0, flush}, 32'd0);
    chk("bn_ex_valid", {31'd0, ex_valid}, 32'd1);
    tick();
    chk("bn_follower_valid", {31'd0, ex_valid}, 32'd1);
    chk("bn_follower_result", ex_result, 32'd2);
    chk("bn_follower_flush", {31'd0, flush}, 32'd0);
    tick();

    // Back-pressure: three instructions, ex_ready low for cycles 0..3
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      ex_ready = (c >= 4);
      if (idx < 3)
        drive(2'b10, 6'h20, 0, idx + 1, idx + 1, 32'd0, 0, 1'b0, 32'd0,
              5'd1, 5'd2, 5'(idx + 1), 1'b1);
      else
        id_valid = 1'b0;
      @(negedge clk);
      rdy = id_ready;
      if (ex_valid && ex_ready) got.push_back(ex_result);
      if (c == 2 || c == 3) begin
        chk($sformatf("bp_id_ready_low_c%0d", c), {31'd0, rdy}, 32'd0);
        chk($sformatf("bp_ex_hold_c%0d", c), ex_result, 32'd2);
        chk($sformatf("bp_alu_rs_hold_c%0d", c), alu_rs, 32'd2);
      end
      @(posedge clk);
      if (id_valid && rdy) idx++;
      #1;
    end
    id_valid = 1'b0;
    chk("bp_count", got.size(), 32'd3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("bp_order_%0d", k), (k < got.size()) ? got[k] : 32'hDEAD, 32'(2 * (k + 1)));

    // Async reset asserted mid-stall between clock edges
    ex_ready = 1'b0;
    drive(2'b10, 6'h22, 0, 32'd10, 32'd3, 32'd0, 0, 1'b0, 32'd0, 5'd1, 5'd2, 5'd6, 1'b1);
    tick();
    drive(2'b10, 6'h22, 0, 32'd20, 32'd3, 32'd0, 0, 1'b0, 32'd0, 5'd1, 5'd2, 5'd7, 1'b1);
    tick();
    id_valid = 1'b0;
    tick();
    chk("rs_pre_valid", {31'd0, ex_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rs_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rs_ex_result", ex_result, 32'd0);
    chk("rs_ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
    chk("rs_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    chk("rs_alu_rs", alu_rs, 32'd0);
    chk("rs_ex_rd_idx", {27'd0, ex_rd_idx}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ex_ready = 1'b1;
    tick();

    // Back-to-back dependency: add $3 = 2+2, then addi $4 = $3 + 1 (stale rs)
    drive(2'b10, 6'h20, 0, 32'd2, 32'd2, 32'd0, 0, 1'b0, 32'd0, 5'd1, 5'd2, 5'd3, 1'b1);
    tick();
    drive(2'b00, 6'h00, 0, 32'd0, 32'd0, 32'd1, 1, 1'b0, 32'd0, 5'd3, 5'd0, 5'd4, 1'b1);
    tick();
    id_valid = 1'b0;
    chk("fw_first_result", ex_result, 32'd4);
    tick();
`ifdef ALU_FWD_EN
    chk("fw_second_result", ex_result, 32'd5);
`else
    chk("fw_second_result", ex_result, 32'd1);
`endif
    chk("fw_rd_idx", {27'd0, ex_rd_idx}, 32'd4);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
